vram_plane_fetch: RTL and testbench

//  Fetch stage directly upstream of the VDP pixel/colour stage. Takes its 13-bit cell address.

---
 rtl/vram_plane_fetch.sv | 162 ++++++++++++++++
 tb/tb_vram_plane_fetch.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_plane_fetch.sv
// Six-plane VRAM fetch stage with a double-buffered cell output and CPU access
// interleaving into the free slots of each 8-pixel cell.
module vram_plane_fetch #(
    parameter logic [15:0] PLANE_BASE = 16'h0000,
    parameter logic [15:0] PLANE_SIZE = 16'h2000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [8:0]  h,
    input  logic        disp_en,
    input  logic [12:0] vdp_addr,
    output logic [15:0] vram_addr,
    output logic        vram_rd,
    output logic        vram_wr,
    output logic [7:0]  vram_dout,
    input  logic [7:0]  vram_din,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic [7:0]  fg1,
    output logic [7:0]  fg2,
    output logic [7:0]  fg3,
    output logic [7:0]  bg1,
    output logic [7:0]  bg2,
    output logic [7:0]  bg3
);

    // The cycle in which a grant fires is the issue cycle; the arbiter then
    // spends exactly one clock in ACK, giving one access per two clocks.
    typedef enum logic {
        ARB_IDLE,
        ARB_ACK
    } arb_state_t;

    arb_state_t  state;
    arb_state_t  state_next;

    logic [2:0]  slot;
    logic        started;
    logic        cell_disp;
    logic        valid;
    logic        ack_we;
    logic [12:0] cell_addr;
    logic [15:0] last_addr;
    logic [7:0]  shadow [6];

    logic        fetch;
    logic        slot_free;
    logic        issue;
    logic [12:0] fetch_cell;
    logic [15:0] fetch_addr;
    logic        unused_h;

    assign slot     = h[2:0];
    assign unused_h = ^h[8:3];

    // Slot 0 decides the cell from the live inputs; later slots use the latched cell.
    always_comb begin
        fetch      = 1'b0;
        slot_free  = 1'b0;
        fetch_cell = (slot == 3'd0) ? vdp_addr : cell_addr;
        fetch_addr = PLANE_BASE + 16'(slot) * PLANE_SIZE + {3'b000, fetch_cell};
        if (slot == 3'd0) begin
            fetch     = started && disp_en;
            slot_free = !disp_en;
        end else begin
            fetch     = cell_disp && (slot <= 3'd5);
            slot_free = !cell_disp || (slot >= 3'd6);
        end
        issue = started && (state == ARB_IDLE) && cpu_req && slot_free;
    end

    always_comb begin
        state_next = state;
        vram_rd    = 1'b0;
        vram_wr    = 1'b0;
        vram_addr  = last_addr;
        vram_dout  = 8'h00;
        cpu_ack    = 1'b0;
        cpu_rdata  = 8'h00;
        if (fetch) begin
            vram_rd   = 1'b1;
            vram_addr = fetch_addr;
        end else if (issue) begin
            vram_addr = cpu_addr;
            vram_rd   = !cpu_we;
            vram_wr   = cpu_we;
            vram_dout = cpu_wdata;
        end
        case (state)
            ARB_IDLE: begin
                if (issue) begin
                    state_next = ARB_ACK;
                end
            end
            ARB_ACK: begin
                cpu_ack    = 1'b1;
                cpu_rdata  = ack_we ? 8'h00 : vram_din;
                state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Shadow bytes fill during the cell and are only exposed at the next slot 0,
    // so the colour stage sees one stable byte set per cell.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            started   <= 1'b0;
            cell_disp <= 1'b0;
            valid     <= 1'b0;
            ack_we    <= 1'b0;
            cell_addr <= 13'h0000;
            last_addr <= 16'h0000;
            for (int i = 0; i < 6; i++) begin
                shadow[i] <= 8'h00;
            end
            fg1 <= 8'h00;
            fg2 <= 8'h00;
            fg3 <= 8'h00;
            bg1 <= 8'h00;
            bg2 <= 8'h00;
            bg3 <= 8'h00;
        end else begin
            started   <= 1'b1;
            last_addr <= vram_addr;
            if (issue) begin
                ack_we <= cpu_we;
            end
            if (slot == 3'd0) begin
                cell_disp <= started && disp_en;
                cell_addr <= vdp_addr;
                valid     <= 1'b0;
                if (valid) begin
                    fg1 <= shadow[0];
                    fg2 <= shadow[1];
                    fg3 <= shadow[2];
                    bg1 <= shadow[3];
                    bg2 <= shadow[4];
                    bg3 <= shadow[5];
                end
            end else if (cell_disp && (slot <= 3'd6)) begin
                shadow[slot - 3'd1] <= vram_din;
                if (slot == 3'd6) begin
                    valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vram_plane_fetch.sv
// Bench for vram_plane_fetch: directed vector table, hand-written corner
// sequences and a randomized run against a slot-level reference model.
module tb_vram_plane_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [8:0]  h;
    logic        disp_en;
    logic [12:0] vdp_addr;
    logic [15:0] vram_addr;
    logic        vram_rd;
    logic        vram_wr;
    logic [7:0]  vram_dout;
    logic [7:0]  vram_din;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic [7:0]  fg1, fg2, fg3, bg1, bg2, bg3;

    int checks = 0;
    int errors = 0;

    logic        fill;
    logic [7:0]  mem [65536];
    logic [7:0]  ref_mem [65536];

    vram_plane_fetch dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .h         (h),
        .disp_en   (disp_en),
        .vdp_addr  (vdp_addr),
        .vram_addr (vram_addr),
        .vram_rd   (vram_rd),
        .vram_wr   (vram_wr),
        .vram_dout (vram_dout),
        .vram_din  (vram_din),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .fg1       (fg1),
        .fg2       (fg2),
        .fg3       (fg3),
        .bg1       (bg1),
        .bg2       (bg2),
        .bg3       (bg3)
    );

    always #5 clk = ~clk;

    // Single-port synchronous VRAM: read data appears one clock after vram_rd.
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 65536; i++) begin
                mem[i] <= 8'h10 + 8'(i >> 13);
            end
        end else begin
            if (vram_rd) vram_din <= mem[vram_addr];
            if (vram_wr) mem[vram_addr] <= vram_dout;
        end
    end

    typedef struct {
        logic        disp;
        logic [12:0] vdp;
        logic        exp_rd;
        logic [15:0] exp_addr;
        logic        exp_loaded;
    } vec_t;

    vec_t vecs [16];

    function automatic logic [47:0] plane_set(input logic loaded);
        return loaded ? 48'h101112131415 : 48'h0;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (h=%0d t=%0t)", name, act, exp, h, $time);
        end
    endtask

    task automatic step(input logic d, input logic [12:0] a);
        @(posedge clk);
        #1;
        h        = h + 9'd1;
        disp_en  = d;
        vdp_addr = a;
    endtask

    task automatic apply_stimulus(input vec_t v);
        step(v.disp, v.vdp);
        #3;
    endtask

    function automatic logic [47:0] planes();
        return {fg1, fg2, fg3, bg1, bg2, bg3};
    endfunction

    // reference model state
    logic        m_disp;
    logic [12:0] m_cell;
    logic [7:0]  m_bytes [6];
    logic [47:0] exp_out;
    logic [47:0] load_val;
    logic        load_pend;
    logic        m_ack;
    logic        m_ack_we;
    logic [7:0]  m_ack_data;
    logic [15:0] m_last;
    logic        drop_next;
    logic        fetch_e;
    logic        issue_e;
    logic [15:0] e_addr;
    logic [2:0]  slot;

    initial begin
        for (int i = 0; i < 16; i++) begin
            int s;
            s = i % 8;
            if (i < 8) begin
                vecs[i].disp       = 1'b1;
                vecs[i].vdp        = (s == 0) ? 13'h0ec0 : 13'h1fff;
                vecs[i].exp_rd     = (s <= 5);
                vecs[i].exp_addr   = (s <= 5) ? 16'h0ec0 + 16'(s) * 16'h2000 : 16'haec0;
                vecs[i].exp_loaded = 1'b0;
            end else begin
                vecs[i].disp       = 1'b0;
                vecs[i].vdp        = 13'h1fff;
                vecs[i].exp_rd     = 1'b0;
                vecs[i].exp_addr   = 16'haec0;
                vecs[i].exp_loaded = (s != 0);
            end
        end
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h10 + 8'(i >> 13);

        reset_n   = 1'b0;
        fill      = 1'b1;
        h         = 9'd0;
        disp_en   = 1'b1;
        vdp_addr  = 13'h0ec0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;

        step(1'b1, 13'h0ec0);
        fill = 1'b0;
        while (h[2:0] != 3'd5) step(1'b1, 13'h0ec0);
        #3;
        check_output("reset_addr",  64'(vram_addr), 64'h0);
        check_output("reset_rdwr",  64'({vram_rd, vram_wr}), 64'h0);
        check_output("reset_dout",  64'(vram_dout), 64'h0);
        check_output("reset_cpu",   64'({cpu_ack, cpu_rdata}), 64'h0);
        check_output("reset_planes", 64'(planes()), 64'h0);

        reset_n = 1'b1;
        repeat (2) begin
            step(1'b1, 13'h0ec0);
            #3;
            check_output("post_reset_idle_rd", 64'(vram_rd), 64'h0);
        end

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("vec%0d_rd", i), 64'(vram_rd), 64'(vecs[i].exp_rd));
            check_output($sformatf("vec%0d_addr", i), 64'(vram_addr), 64'(vecs[i].exp_addr));
            check_output($sformatf("vec%0d_planes", i), 64'(planes()), 64'(plane_set(vecs[i].exp_loaded)));
        end

        // mid-fetch reset at slot 3 of cell C
        repeat (4) begin
            step(1'b1, 13'h0ec0);
            #3;
        end
        check_output("pre_reset_planes", 64'(planes()), 64'h101112131415);
        reset_n = 1'b0;
        #1;
        check_output("midreset_planes", 64'(planes()), 64'h0);
        check_output("midreset_rd", 64'(vram_rd), 64'h0);
        check_output("midreset_addr", 64'(vram_addr), 64'h0);
        step(1'b1, 13'h0ec0);
        reset_n = 1'b1;
        repeat (3) begin
            step(1'b1, 13'h0ec0);
            #3;
            check_output("midreset_nofetch", 64'(vram_rd), 64'h0);
        end
        for (int s = 0; s < 8; s++) begin
            step(1'b1, 13'h0ec0);
            #3;
            check_output("refill_rd", 64'(vram_rd), 64'(s <= 5));
            check_output("refill_planes_zero", 64'(planes()), 64'h0);
        end
        step(1'b1, 13'h0ec0);
        #3;
        check_output("latency_slot0_zero", 64'(planes()), 64'h0);
        for (int s = 1; s < 8; s++) begin
            step(1'b1, 13'h0ec0);
            #3;
            check_output("latency_loaded", 64'(planes()), 64'h101112131415);
        end

        // contention: read request raised at slot 1 waits for slot 6
        step(1'b1, 13'h0ec0);
        #3;
        for (int s = 1; s < 8; s++) begin
            step(1'b1, 13'h0ec0);
            if (s == 1) begin
                cpu_req   = 1'b1;
                cpu_we    = 1'b0;
                cpu_addr  = 16'h1234;
                cpu_wdata = 8'h00;
            end
            #3;
            if (s <= 5) begin
                check_output("cont_fetch", 64'({vram_rd, vram_wr, vram_addr}), 64'({2'b10, 16'h0ec0 + 16'(s) * 16'h2000}));
                check_output("cont_noack", 64'(cpu_ack), 64'h0);
            end else if (s == 6) begin
                check_output("cont_issue", 64'({vram_rd, vram_wr, vram_addr}), 64'({2'b10, 16'h1234}));
                check_output("cont_noack6", 64'(cpu_ack), 64'h0);
            end else begin
                check_output("cont_ack", 64'({cpu_ack, cpu_rdata}), 64'({1'b1, 8'h10}));
            end
        end

        // slot-7 write completes alongside the next plane-0 read
        for (int s = 0; s < 7; s++) begin
            step(1'b1, 13'h0ec0);
            cpu_req = 1'b0;
            #3;
        end
        step(1'b1, 13'h0ec0);
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 16'h4321;
        cpu_wdata = 8'ha5;
        #3;
        check_output("slot7_write", 64'({vram_rd, vram_wr, vram_addr, vram_dout}), 64'({2'b01, 16'h4321, 8'ha5}));
        ref_mem[16'h4321] = 8'ha5;
        step(1'b1, 13'h0ec0);
        #3;
        check_output("slot7_ack", 64'({cpu_ack, cpu_rdata}), 64'({1'b1, 8'h00}));
        check_output("slot7_plane0", 64'({vram_rd, vram_wr, vram_addr}), 64'({2'b10, 16'h0ec0}));
        cpu_req = 1'b0;
        for (int s = 1; s < 8; s++) begin
            step(1'b1, 13'h0ec0);
            #3;
        end

        // randomized run against the slot-rule model
        m_disp    = 1'b1;
        m_cell    = 13'h0ec0;
        for (int k = 0; k < 6; k++) m_bytes[k] = 8'h10 + 8'(k);
        exp_out   = 48'h101112131415;
        m_ack     = 1'b0;
        m_ack_we  = 1'b0;
        m_ack_data = 8'h00;
        m_last    = 16'haec0;
        drop_next = 1'b0;
        for (int cyc = 0; cyc < 1600; cyc++) begin
            step($urandom_range(3) != 0, 13'($urandom));
            slot = h[2:0];
            if (drop_next) begin
                cpu_req   = 1'b0;
                drop_next = 1'b0;
            end else if (!cpu_req && $urandom_range(2) == 0) begin
                cpu_req   = 1'b1;
                cpu_we    = 1'($urandom_range(1));
                cpu_addr  = 16'($urandom);
                cpu_wdata = 8'($urandom);
            end
            #3;
            load_pend = 1'b0;
            if (slot == 3'd0) begin
                if (m_disp) begin
                    load_val  = {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3], m_bytes[4], m_bytes[5]};
                    load_pend = 1'b1;
                end
                m_disp = disp_en;
                m_cell = vdp_addr;
            end
            fetch_e = m_disp && (slot <= 3'd5);
            issue_e = cpu_req && !fetch_e && !m_ack;
            e_addr  = fetch_e ? 16'(slot) * 16'h2000 + {3'b000, m_cell} : (issue_e ? cpu_addr : m_last);
            check_output("rand_vram_bus", 64'({vram_rd, vram_wr, vram_addr, vram_dout}),
                         64'({fetch_e || (issue_e && !cpu_we), issue_e && cpu_we, e_addr, issue_e ? cpu_wdata : 8'h00}));
            check_output("rand_cpu_resp", 64'({cpu_ack, cpu_rdata}),
                         64'({m_ack, (m_ack && !m_ack_we) ? m_ack_data : 8'h00}));
            check_output("rand_planes", 64'(planes()), 64'(exp_out));
            if (fetch_e) m_bytes[slot] = ref_mem[e_addr];
            if (issue_e) begin
                m_ack_we = cpu_we;
                if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
                else m_ack_data = ref_mem[cpu_addr];
            end
            if (m_ack) drop_next = 1'b1;
            m_ack  = issue_e;
            m_last = e_addr;
            if (load_pend) exp_out = load_val;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
